// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration path.
// Used by the per-CLB loader and by the LUTs it configures.
package lut_cfg_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_COMMIT = ST_COMMIT,
    S_DONE   = ST_DONE
  } state_t;

  // Two LUT halves plus the fracture bit.
  function automatic int cfg_width(input int inputs);
    return 2 * (2 ** inputs) + 1;
  endfunction

endpackage

// File: rtl/lut_cfg_shreg.sv
// Serial-to-parallel word assembler with a bit counter.
// last_bit flags the cycle whose accepted bit completes the word.
module lut_cfg_shreg #(
  parameter int W = 33,
  localparam int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         last_bit
);

  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign last_bit = (cnt_q == CW'(W - 1));
  assign word     = sh_q;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      sh_d  = {sh_q[W-2:0], bit_in};
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lut_cfg_loader.sv
// Per-CLB bitstream loader: shifts serial bits into LUT-sized
// words and commits each to its target with a one-cycle enable.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS      = 4,
  parameter int NUM_TARGETS = 4,
  localparam int MEM_SIZE   = 2 ** INPUTS,
  localparam int CFG_WIDTH  = 2 * MEM_SIZE + 1,
  localparam int TGT_W      =
    (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   config_clk,
  input  logic                   config_rst_n,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [CFG_WIDTH-1:0]   config_in,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic                   busy,
  output logic                   done
);

  state_t state_q, state_d;

  logic [TGT_W-1:0]       tgt_q, tgt_d;
  logic [NUM_TARGETS-1:0] en_q, en_d;
  logic rdy_q, rdy_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic clr, accept, last_bit;

  // ready is only ever high in SHIFT
  assign accept = bit_valid & rdy_q;

  lut_cfg_shreg #(.W(CFG_WIDTH)) u_shreg (
    .clk      (config_clk),
    .rst_n    (config_rst_n),
    .clr      (clr),
    .shift_en (accept),
    .bit_in   (bit_in),
    .word     (config_in),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    en_d    = '0;
    rdy_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done_d = (state_q == S_DONE);
        if (start) begin
          state_d = S_SHIFT;
          tgt_d   = '0;
          clr     = 1'b1;
          rdy_d   = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        rdy_d  = 1'b1;
        busy_d = 1'b1;
        if (accept && last_bit) begin
          state_d = S_COMMIT;
          rdy_d   = 1'b0;
          en_d    = NUM_TARGETS'(1) << tgt_q;
        end
      end
      S_COMMIT: begin
        if (tgt_q == TGT_W'(NUM_TARGETS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
          tgt_d   = tgt_q + 1'b1;
          rdy_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      en_q    <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign config_en = en_q;
  assign bit_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: table words, random stalls, reset
// mid-load and start handling, checked against a commit scoreboard.
module tb_lut_cfg_loader;

  localparam int W  = 33;
  localparam int NT = 4;

  typedef struct {
    logic [W-1:0]  w;
    logic [NT-1:0] en;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic bit_ready, busy, done;
  logic [W-1:0]  cfg;
  logic [NT-1:0] en;

  logic start1 = 1'b0, bit_in1 = 1'b0, bit_valid1 = 1'b0;
  logic bit_ready1, busy1, done1;
  logic [W-1:0] cfg1;
  logic [0:0]   en1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_rise = 0;
  int en1_cnt = 0;
  logic [NT-1:0] prev_en = '0;
  logic prev_done = 1'b0;

  vec_t tbl[4];
  vec_t obs_q[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  lut_cfg_loader #(.INPUTS(4), .NUM_TARGETS(NT)) u_dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .config_in    (cfg),
    .config_en    (en),
    .busy         (busy),
    .done         (done)
  );

  lut_cfg_loader #(.INPUTS(4), .NUM_TARGETS(1)) u_dut1 (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (start1),
    .bit_in       (bit_in1),
    .bit_valid    (bit_valid1),
    .bit_ready    (bit_ready1),
    .config_in    (cfg1),
    .config_en    (en1),
    .busy         (busy1),
    .done         (done1)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (en != '0) begin
      chk("commit_ready_low", bit_ready, 0);
      chk("commit_one_cycle", prev_en, 0);
      obs_q.push_back('{w: cfg, en: en});
    end
    if (en1 != '0) en1_cnt++;
    if (done && !prev_done) done_rise = cyc;
    prev_en   = en;
    prev_done = done;
  end

  task automatic send(input logic [W-1:0] w, input int hi,
                      input int lo, input bit stall);
    int i = hi;
    int g = 0;
    while (i >= lo && g < 4000) begin
      @(negedge clk);
      g++;
      start = 1'b0;
      if (stall && $urandom_range(0, 2) == 0) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
      end else begin
        bit_valid = 1'b1;
        bit_in    = w[i];
        if (bit_ready) i--;
      end
    end
    if (i >= lo) chk("send_timeout", 64'(i), 64'(lo - 1));
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 600) begin
      @(negedge clk);
      start = 1'b0;
      g++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic gen_random();
    exp_q.delete();
    for (int k = 0; k < NT; k++)
      exp_q.push_back('{w: {1'($urandom), $urandom},
                        en: NT'(1) << k});
  endtask

  task automatic load_exp(input bit stall);
    for (int k = 0; k < exp_q.size(); k++)
      send(exp_q[k].w, W - 1, 0, stall);
  endtask

  task automatic check_commits(input string name);
    chk({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      chk({name, "_en"}, obs_q[k].en, exp_q[k].en);
      chk({name, "_word"}, obs_q[k].w, exp_q[k].w);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [W-1:0] w1;

    tbl[0] = '{w: 33'h1_DEADBEEF, en: 4'b0001};
    tbl[1] = '{w: 33'h0_12345678, en: 4'b0010};
    tbl[2] = '{w: 33'h0_A5A55A5A, en: 4'b0100};
    tbl[3] = '{w: 33'h1_0F0FF0F1, en: 4'b1000};

    // 1: reset, then idle with valid asserted
    #1 rst_n = 1'b0;
    bit_valid = 1'b1;
    bit_valid1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg1", cfg1, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_out", {bit_ready, busy, done, en, cfg}, 0);
      chk("idle_out1", {bit_ready1, busy1, done1, en1}, 0);
    end
    obs_q.delete();

    // 2: single word on the one-target loader
    w1 = 33'h1_DEADBEEF;
    @(negedge clk);
    start1 = 1'b1;
    begin
      int i = W - 1;
      int g = 0;
      while (i >= 0 && g < 200) begin
        @(negedge clk);
        g++;
        start1 = 1'b0;
        bit_valid1 = 1'b1;
        bit_in1 = w1[i];
        if (bit_ready1) i--;
      end
    end
    @(negedge clk);
    bit_valid1 = 1'b0;
    chk("t2_en", en1, 1);
    chk("t2_word", cfg1, 33'h1_DEADBEEF);
    chk("t2_ready", bit_ready1, 0);
    @(negedge clk);
    chk("t2_en_off", en1, 0);
    chk("t2_done", done1, 1);
    chk("t2_busy", busy1, 0);
    chk("t2_en_cycles", 64'(en1_cnt), 1);

    // 3: four table words, continuous valid
    for (int k = 0; k < 4; k++) exp_q.push_back(tbl[k]);
    pulse_start(s);
    for (int k = 0; k < 4; k++) send(tbl[k].w, W - 1, 0, 1'b0);
    wait_done();
    chk("t3_done_latency", 64'(done_rise - s), 64'(1 + 4 * 34));
    repeat (4) @(negedge clk);
    chk("t3_done_held", done, 1);
    chk("t3_busy", busy, 0);
    check_commits("t3");

    // 4: same table with random valid stalls
    for (int k = 0; k < 4; k++) exp_q.push_back(tbl[k]);
    pulse_start(s);
    for (int k = 0; k < 4; k++) send(tbl[k].w, W - 1, 0, 1'b1);
    wait_done();
    check_commits("t4");

    for (int r = 0; r < 3; r++) begin
      gen_random();
      pulse_start(s);
      load_exp(1'b1);
      wait_done();
      check_commits("rand");
    end

    // 5: reset after 20 bits of the first word
    gen_random();
    pulse_start(s);
    send(exp_q[0].w, W - 1, W - 20, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_out", {bit_ready, busy, done, en, cfg}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_commit", 64'(obs_q.size()), 0);
    pulse_start(s);
    load_exp(1'b1);
    wait_done();
    check_commits("t5_reload");

    // 6: start mid-SHIFT is ignored; start in DONE restarts
    gen_random();
    pulse_start(s);
    send(exp_q[0].w, W - 1, W - 10, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    start = 1'b1;
    send(exp_q[0].w, W - 11, 0, 1'b0);
    for (int k = 1; k < NT; k++) send(exp_q[k].w, W - 1, 0, 1'b0);
    wait_done();
    check_commits("t6_mid");
    @(negedge clk);
    bit_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_done_clr", done, 0);
    chk("t6_busy", busy, 1);
    chk("t6_ready", bit_ready, 1);
    gen_random();
    load_exp(1'b0);
    wait_done();
    check_commits("t6_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
